// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification for seq_alu.
// Pure declarations: no latency, no backpressure.
package seq_alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b01100;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b00001;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    function automatic logic op_is_single(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_NEG,
            OP_SHL, OP_SHR, OP_SHRA, OP_ROL, OP_ROR: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_div.sv
// Signed restoring divider (SEQ_ALU_DIV_EN only): WIDTH iterations after i_start,
// o_done is a combinational strobe on the last iteration, no backpressure.
`ifdef SEQ_ALU_DIV_EN
module seq_alu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);
    localparam int LW = $clog2(WIDTH);

    logic             r_run;
    logic [LW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_d;
    logic             r_sa;
    logic             r_sq;

    logic [WIDTH:0]   w_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_n;
    logic [WIDTH-1:0] w_quo_n;

    // Dividend magnitude is shifted out of r_quo while quotient bits shift in.
    assign w_sh    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_sh >= {1'b0, r_d});
    assign w_diff  = w_sh[WIDTH-1:0] - r_d;
    assign w_rem_n = w_ge ? w_diff : w_sh[WIDTH-1:0];
    assign w_quo_n = {r_quo[WIDTH-2:0], w_ge};

    assign o_done = r_run && (r_cnt == LW'(WIDTH - 1));
    assign o_quo  = r_sq ? -w_quo_n : w_quo_n;
    assign o_rem  = r_sa ? -w_rem_n : w_rem_n;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_d   <= '0;
            r_sa  <= 1'b0;
            r_sq  <= 1'b0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= i_a[WIDTH-1] ? -i_a : i_a;
            r_d   <= i_b[WIDTH-1] ? -i_b : i_b;
            r_sa  <= i_a[WIDTH-1];
            r_sq  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
        end else if (r_run) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops and illegal opcodes latency 1, Booth MUL / DIV latency WIDTH+1;
// start is honoured only in IDLE (no queueing). Divider present only with SEQ_ALU_DIV_EN.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Zout,
    output logic               illegal,
    output logic               div_zero
);
    localparam int LW = $clog2(WIDTH);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_illegal;
    logic               r_div_zero;
    logic [2*WIDTH-1:0] r_zout;
    logic [WIDTH:0]     r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_m;
    logic               r_qm1;
    logic [LW-1:0]      r_cnt;

    logic [LW-1:0]      w_amt;
    logic [LW:0]        w_inv;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH:0]     w_mext;
    logic [WIDTH:0]     w_sum;
    logic               w_mul_last;

    assign busy     = r_busy;
    assign done     = r_done;
    assign Zout     = r_zout;
    assign illegal  = r_illegal;
    assign div_zero = r_div_zero;

    // WIDTH is a power of two, so the low bits of B are B mod WIDTH.
    assign w_amt = B[LW-1:0];
    assign w_inv = (LW+1)'(WIDTH) - {1'b0, w_amt};

    always_comb begin
        w_res = '0;
        case (opcode)
            OP_ADD:  w_res = A + B;
            OP_SUB:  w_res = A - B;
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_NOT:  w_res = ~A;
            OP_NEG:  w_res = -A;
            OP_SHL:  w_res = A << w_amt;
            OP_SHR:  w_res = A >> w_amt;
            OP_SHRA: w_res = $signed(A) >>> w_amt;
            OP_ROL:  w_res = (A << w_amt) | (A >> w_inv);
            OP_ROR:  w_res = (A >> w_amt) | (A << w_inv);
            default: w_res = '0;
        endcase
    end

    // Booth step on a WIDTH+1 bit high half so that subtracting the most-negative M cannot overflow.
    assign w_mext     = {r_m[WIDTH-1], r_m};
    assign w_mul_last = (r_cnt == LW'(WIDTH - 1));

    always_comb begin
        w_sum = r_hi;
        if (r_lo[0] && !r_qm1) begin
            w_sum = r_hi - w_mext;
        end else if (!r_lo[0] && r_qm1) begin
            w_sum = r_hi + w_mext;
        end
    end

`ifdef SEQ_ALU_DIV_EN
    logic             w_div_start;
    logic             w_div_done;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_div_start = (r_state == S_IDLE) && start && (opcode == OP_DIV) && (B != '0);

    seq_alu_div #(.WIDTH(WIDTH)) u_div (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_start (w_div_start),
        .i_a     (A),
        .i_b     (B),
        .o_done  (w_div_done),
        .o_quo   (w_quo),
        .o_rem   (w_rem)
    );
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_div_zero <= 1'b0;
            r_zout     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_m        <= '0;
            r_qm1      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        case (opcode)
                            OP_MUL: begin
                                r_state <= S_MUL;
                                r_busy  <= 1'b1;
                                r_hi    <= '0;
                                r_lo    <= B;
                                r_m     <= A;
                                r_qm1   <= 1'b0;
                                r_cnt   <= '0;
                            end
`ifdef SEQ_ALU_DIV_EN
                            OP_DIV: begin
                                if (B == '0) begin
                                    r_state    <= S_DONE;
                                    r_done     <= 1'b1;
                                    r_zout     <= {A, {WIDTH{1'b1}}};
                                    r_illegal  <= 1'b0;
                                    r_div_zero <= 1'b1;
                                end else begin
                                    r_state <= S_DIV;
                                    r_busy  <= 1'b1;
                                end
                            end
`endif
                            default: begin
                                r_state    <= S_DONE;
                                r_done     <= 1'b1;
                                r_zout     <= {{WIDTH{1'b0}}, w_res};
                                r_illegal  <= !op_is_single(opcode);
                                r_div_zero <= 1'b0;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    r_hi  <= {w_sum[WIDTH], w_sum[WIDTH:1]};
                    r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                    r_qm1 <= r_lo[0];
                    if (w_mul_last) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_zout     <= {w_sum, r_lo[WIDTH-1:1]};
                        r_illegal  <= 1'b0;
                        r_div_zero <= 1'b0;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    if (w_div_done) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_zout     <= {w_rem, w_quo};
                        r_illegal  <= 1'b0;
                        r_div_zero <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed vectors plus random ops against a behavioural model.
module tb_seq_alu;
    localparam logic [4:0] T_ADD  = 5'b01100;
    localparam logic [4:0] T_SUB  = 5'b00100;
    localparam logic [4:0] T_AND  = 5'b01010;
    localparam logic [4:0] T_OR   = 5'b01011;
    localparam logic [4:0] T_NOT  = 5'b10010;
    localparam logic [4:0] T_NEG  = 5'b10001;
    localparam logic [4:0] T_MUL  = 5'b01111;
    localparam logic [4:0] T_DIV  = 5'b00001;
    localparam logic [4:0] T_SHL  = 5'b00111;
    localparam logic [4:0] T_SHR  = 5'b00101;
    localparam logic [4:0] T_SHRA = 5'b00110;
    localparam logic [4:0] T_ROL  = 5'b01001;
    localparam logic [4:0] T_ROR  = 5'b01000;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] Zout;
    logic        illegal;
    logic        div_zero;

    int n_checks = 0;
    int n_errs   = 0;

    logic [4:0] op_tab [0:12] = '{T_ADD, T_SUB, T_AND, T_OR, T_NOT, T_NEG, T_MUL,
                                  T_DIV, T_SHL, T_SHR, T_SHRA, T_ROL, T_ROR};

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .opcode   (opcode),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Zout     (Zout),
        .illegal  (illegal),
        .div_zero (div_zero)
    );

    function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [63:0] z, output logic il, output logic dz, output int lat);
        logic [31:0] r;
        int s;
        longint qa, qb, q, rm;
        s = int'(b % 32);
        r = 32'h0; z = 64'h0; il = 1'b0; dz = 1'b0; lat = 1;
        qa = longint'($signed(a));
        qb = longint'($signed(b));
        case (op)
            T_ADD:  r = a + b;
            T_SUB:  r = a - b;
            T_AND:  r = a & b;
            T_OR:   r = a | b;
            T_NOT:  r = ~a;
            T_NEG:  r = 32'h0 - a;
            T_SHL:  r = a << s;
            T_SHR:  r = a >> s;
            T_SHRA: begin r = a; for (int i = 0; i < s; i++) r = {r[31], r[31:1]}; end
            T_ROL:  begin r = a; for (int i = 0; i < s; i++) r = {r[30:0], r[31]}; end
            T_ROR:  begin r = a; for (int i = 0; i < s; i++) r = {r[0], r[31:1]}; end
            T_MUL:  begin z = 64'(qa * qb); lat = 33; end
            T_DIV: begin
`ifdef SEQ_ALU_DIV_EN
                if (b == 32'h0) begin
                    z = {a, 32'hFFFF_FFFF}; dz = 1'b1;
                end else begin
                    q = qa / qb; rm = qa % qb;
                    z = {rm[31:0], q[31:0]}; lat = 33;
                end
`else
                il = 1'b1;
`endif
            end
            default: il = 1'b1;
        endcase
        if (op != T_MUL && op != T_DIV) z = {32'h0, r};
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] z, output logic il, output logic dz);
        start = 1'b1; opcode = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom; opcode = 5'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        z = Zout; il = illegal; dz = div_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; start = 1'b0; opcode = 5'h0; A = 32'h0; B = 32'h0;
        #2;
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (Zout !== 64'h0) begin n_errs++; $display("FAIL reset_zout got=%h exp=0", Zout); end
        n_checks++; if (illegal !== 1'b0) begin n_errs++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        n_checks++; if (div_zero !== 1'b0) begin n_errs++; $display("FAIL reset_divz got=%b exp=0", div_zero); end
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int lat;
        logic [63:0] z, ez;
        logic il, dz, eil, edz;
        int elat;
        do_op(T_ADD, 32'h7FFF_FFFF, 32'h1, lat, z, il, dz);
        n_checks++; if (lat !== 1) begin n_errs++; $display("FAIL add_lat got=%0d exp=1", lat); end
        n_checks++; if (z !== 64'h0000_0000_8000_0000) begin n_errs++; $display("FAIL add_zout got=%h exp=0000000080000000", z); end
        do_op(T_ROR, 32'h1, 32'd33, lat, z, il, dz);
        n_checks++; if (z !== 64'h0000_0000_8000_0000) begin n_errs++; $display("FAIL ror_zout got=%h exp=0000000080000000", z); end
        do_op(5'b11111, 32'h1234, 32'h5678, lat, z, il, dz);
        n_checks++; if (il !== 1'b1 || z !== 64'h0 || lat !== 1) begin n_errs++; $display("FAIL illegal_op got il=%b z=%h lat=%0d exp il=1 z=0 lat=1", il, z, lat); end
`ifdef SEQ_ALU_DIV_EN
        ez = 64'hFFFF_FFFF_FFFF_FFFD; eil = 1'b0; edz = 1'b0; elat = 33;
`else
        ez = 64'h0; eil = 1'b1; edz = 1'b0; elat = 1;
`endif
        do_op(T_DIV, 32'hFFFF_FFF9, 32'h2, lat, z, il, dz);
        n_checks++; if (z !== ez || il !== eil || dz !== edz || lat !== elat)
            begin n_errs++; $display("FAIL div_m7_2 got z=%h il=%b dz=%b lat=%0d exp z=%h il=%b dz=%b lat=%0d", z, il, dz, lat, ez, eil, edz, elat); end
`ifdef SEQ_ALU_DIV_EN
        ez = 64'h0000_0005_FFFF_FFFF; eil = 1'b0; edz = 1'b1;
`else
        ez = 64'h0; eil = 1'b1; edz = 1'b0;
`endif
        do_op(T_DIV, 32'h5, 32'h0, lat, z, il, dz);
        n_checks++; if (z !== ez || il !== eil || dz !== edz || lat !== 1)
            begin n_errs++; $display("FAIL div_by_zero got z=%h il=%b dz=%b lat=%0d exp z=%h il=%b dz=%b lat=1", z, il, dz, lat, ez, eil, edz); end
`ifdef SEQ_ALU_DIV_EN
        ez = 64'h0000_0000_8000_0000; eil = 1'b0;
`else
        ez = 64'h0; eil = 1'b1;
`endif
        do_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, z, il, dz);
        n_checks++; if (z !== ez || il !== eil || dz !== 1'b0)
            begin n_errs++; $display("FAIL div_min_m1 got z=%h il=%b dz=%b exp z=%h il=%b dz=0", z, il, dz, ez, eil); end
    endtask

    task automatic test_mul();
        int lat;
        logic [63:0] z;
        logic il, dz;
        do_op(5'b11110, 32'h0, 32'h0, lat, z, il, dz);
        start = 1'b1; opcode = T_MUL; A = 32'hFFFF_FFFD; B = 32'h5;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
        n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL mul_busy got=%b exp=1", busy); end
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                start = 1'b1; opcode = T_ADD;
                n_checks++; if (illegal !== 1'b1) begin n_errs++; $display("FAIL illegal_hold got=%b exp=1", illegal); end
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        n_checks++; if (lat !== 33) begin n_errs++; $display("FAIL mul_lat got=%0d exp=33", lat); end
        n_checks++; if (Zout !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_errs++; $display("FAIL mul_zout got=%h exp=FFFFFFFFFFFFFFF1", Zout); end
        n_checks++; if (busy !== 1'b0 || illegal !== 1'b0) begin n_errs++; $display("FAIL mul_done_flags got busy=%b il=%b exp 0 0", busy, illegal); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || Zout !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_errs++; $display("FAIL mul_pulse got done=%b z=%h exp done=0 z held", done, Zout); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; opcode = T_ADD; A = 32'd1; B = 32'd2;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1 || Zout !== 64'd3) begin n_errs++; $display("FAIL b2b_first got done=%b z=%h exp 1 3", done, Zout); end
        A = 32'd10;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || Zout !== 64'd3) begin n_errs++; $display("FAIL b2b_ignored got done=%b z=%h exp 0 3", done, Zout); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1 || Zout !== 64'd12) begin n_errs++; $display("FAIL b2b_second got done=%b z=%h exp 1 c", done, Zout); end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, elat;
        logic [63:0] z, ez;
        logic il, dz, eil, edz;
        logic [4:0] op;
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 13) == 13) op = 5'($urandom);
            else op = op_tab[$urandom_range(0, 12)];
            a = pick_val();
            b = pick_val();
            ref_model(op, a, b, ez, eil, edz, elat);
            do_op(op, a, b, lat, z, il, dz);
            n_checks++; if (z !== ez) begin n_errs++; $display("FAIL rand_zout op=%b a=%h b=%h got=%h exp=%h", op, a, b, z, ez); end
            n_checks++; if (il !== eil) begin n_errs++; $display("FAIL rand_illegal op=%b got=%b exp=%b", op, il, eil); end
            n_checks++; if (dz !== edz) begin n_errs++; $display("FAIL rand_divz op=%b b=%h got=%b exp=%b", op, b, dz, edz); end
            n_checks++; if (lat !== elat) begin n_errs++; $display("FAIL rand_lat op=%b got=%0d exp=%0d", op, lat, elat); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [63:0] z;
        logic il, dz;
        do_op(T_OR, 32'h1234_5678, 32'h0, lat, z, il, dz);
        start = 1'b1; opcode = T_MUL; A = $urandom; B = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 clr_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errs++; $display("FAIL midrst_flags got busy=%b done=%b exp 0 0", busy, done); end
        n_checks++; if (Zout !== 64'h0) begin n_errs++; $display("FAIL midrst_zout got=%h exp=0", Zout); end
        @(posedge clk); #1 clr_n = 1'b1;
        @(posedge clk); #1;
        do_op(T_ADD, 32'd2, 32'd3, lat, z, il, dz);
        n_checks++; if (z !== 64'd5 || lat !== 1) begin n_errs++; $display("FAIL post_rst_add got z=%h lat=%0d exp z=5 lat=1", z, lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", n_errs, n_checks);
        $fatal(1);
    end

endmodule
